// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage for the 16-bit 5-stage pipeline.
// It owns the program counter and the IF/ID pipeline register, and chooses
// the next PC from three sources: sequential, taken branch or absolute jump.
// It also applies hazard stalls, squashes the wrong-path fetch on a redirect,
// and stops fetching when a HALT instruction is fetched.
//
// Optional feature macro: FETCH_BRCOUNT_EN
//   defined   - brCount is a saturating 16-bit count of taken redirects,
//               cleared only by rst.
//   undefined - there is no counter register and brCount is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | fetching; PC advances by 2 on every non-stalled edge
// HALT  | HALT has been fetched; PC frozen and IF/ID fills with bubbles
//
// Priority on every edge is rst > redirect > stall > normal operation.
// A redirect is honoured in either state, so an older branch in ID still
// squashes a HALT that was fetched behind it.

module fetch_pc_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jmpTrue,
    input  logic [7:0]  brOffset,
    input  logic        jumpTrue,
    input  logic [15:0] jumpAddr,
    input  logic [15:0] instrIn,
    output logic [15:0] pcOut,
    output logic [15:0] ifidInstr,
    output logic [15:0] ifidPc,
    output logic        ifidValid,
    output logic        halted,
    output logic [15:0] brCount
);

    localparam logic [15:0] NOP_WORD  = 16'h0000;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] PC_STEP   = 16'h0002;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [15:0] r_pc;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc;
    logic        r_ifid_valid;

    logic [15:0] w_pc_nxt;
    logic [15:0] w_ifid_instr_nxt;
    logic [15:0] w_ifid_pc_nxt;
    logic        w_ifid_valid_nxt;

    logic        w_redir;
    logic [15:0] w_br_disp;
    logic [15:0] w_br_target;
    logic [15:0] w_redir_target;
    logic [15:0] w_pc_seq;
    logic        w_fetch_is_halt;

    // Redirect qualification and target selection; the comparator and jump
    // operands are not valid while the hazard unit is stalling, so a stall
    // masks both requests. An absolute jump wins over a branch.
    always_comb begin
        w_redir         = (jmpTrue | jumpTrue) & ~stall;
        w_br_disp       = {{7{brOffset[7]}}, brOffset, 1'b0};
        w_br_target     = r_ifid_pc + w_br_disp;
        w_redir_target  = jumpTrue ? jumpAddr : w_br_target;
        w_pc_seq        = r_pc + PC_STEP;
        w_fetch_is_halt = (instrIn == HALT_WORD);
    end

    // State register and all datapath registers; rst dominates every other
    // condition on the edge, including an in-flight stall or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc    <= 16'h0000;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
        end
    end

    // Next-state and next-register values; defaults hold everything, which
    // is exactly the stall behaviour.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_valid_nxt = r_ifid_valid;

        if (w_redir) begin
            // The instruction fetched this cycle is on the wrong path, so it
            // is replaced by a bubble; its address still travels with it.
            w_state_nxt      = ST_RUN;
            w_pc_nxt         = w_redir_target;
            w_ifid_instr_nxt = NOP_WORD;
            w_ifid_pc_nxt    = r_pc;
            w_ifid_valid_nxt = 1'b0;
        end else if (!stall) begin
            case (r_state)
                ST_RUN: begin
                    w_ifid_instr_nxt = instrIn;
                    w_ifid_pc_nxt    = r_pc;
                    w_ifid_valid_nxt = 1'b1;
                    if (w_fetch_is_halt) begin
                        // HALT itself moves down the pipe; fetch freezes here.
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = w_pc_seq;
                    end
                end
                ST_HALT: begin
                    w_ifid_instr_nxt = NOP_WORD;
                    w_ifid_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

`ifdef FETCH_BRCOUNT_EN
    logic [15:0] r_br_count;
    logic        w_br_count_sat;

    // Saturation detect for the redirect counter.
    always_comb begin
        w_br_count_sat = (r_br_count == 16'hFFFF);
    end

    // Saturating count of taken redirects, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count <= 16'h0000;
        end else if (w_redir && !w_br_count_sat) begin
            r_br_count <= r_br_count + 16'h0001;
        end
    end

    assign brCount = r_br_count;
`else
    assign brCount = 16'h0000;
`endif

    assign pcOut     = r_pc;
    assign ifidInstr = r_ifid_instr;
    assign ifidPc    = r_ifid_pc;
    assign ifidValid = r_ifid_valid;
    assign halted    = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit. Inputs are changed 1 ns after the
// rising edge and outputs are sampled at that same point, after the edge
// has settled. Define FETCH_BRCOUNT_EN to exercise the redirect counter.

module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jmpTrue;
    logic [7:0]  brOffset;
    logic        jumpTrue;
    logic [15:0] jumpAddr;
    logic [15:0] instrIn;
    logic [15:0] pcOut;
    logic [15:0] ifidInstr;
    logic [15:0] ifidPc;
    logic        ifidValid;
    logic        halted;
    logic [15:0] brCount;

    int n_checks;
    int n_fail;

`ifdef FETCH_BRCOUNT_EN
    localparam logic [15:0] ONE_REDIR = 16'h0001;
`else
    localparam logic [15:0] ONE_REDIR = 16'h0000;
`endif

    fetch_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmpTrue   (jmpTrue),
        .brOffset  (brOffset),
        .jumpTrue  (jumpTrue),
        .jumpAddr  (jumpAddr),
        .instrIn   (instrIn),
        .pcOut     (pcOut),
        .ifidInstr (ifidInstr),
        .ifidPc    (ifidPc),
        .ifidValid (ifidValid),
        .halted    (halted),
        .brCount   (brCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall    = 1'b0;
        jmpTrue  = 1'b0;
        brOffset = 8'h00;
        jumpTrue = 1'b0;
        jumpAddr = 16'h0000;
        instrIn  = 16'h1111;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pcOut !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", pcOut); end
        n_checks++; if (ifidInstr !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", ifidInstr); end
        n_checks++; if (ifidPc !== 16'h0000) begin n_fail++; $display("FAIL reset_ifidpc got %h want 0000", ifidPc); end
        n_checks++; if (ifidValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifidValid); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (brCount !== 16'h0000) begin n_fail++; $display("FAIL reset_brcount got %h want 0000", brCount); end
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words[0] = 16'h1234; words[1] = 16'h2345; words[2] = 16'h3456;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            instrIn = words[i];
            step();
            n_checks++; if (pcOut !== 16'(2 * (i + 1))) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pcOut, 16'(2 * (i + 1))); end
            n_checks++; if (ifidInstr !== words[i]) begin n_fail++; $display("FAIL seq_instr[%0d] got %h want %h", i, ifidInstr, words[i]); end
            n_checks++; if (ifidPc !== 16'(2 * i)) begin n_fail++; $display("FAIL seq_ifidpc[%0d] got %h want %h", i, ifidPc, 16'(2 * i)); end
            n_checks++; if (ifidValid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got %b want 1", i, ifidValid); end
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (9) step();
        n_checks++; if (ifidPc !== 16'h0010) begin n_fail++; $display("FAIL br_setup_ifidpc got %h want 0010", ifidPc); end
        jmpTrue  = 1'b1;
        brOffset = 8'hFC;
        instrIn  = 16'h7777;
        step();
        n_checks++; if (pcOut !== 16'h0008) begin n_fail++; $display("FAIL br_pc got %h want 0008", pcOut); end
        n_checks++; if (ifidInstr !== 16'h0000) begin n_fail++; $display("FAIL br_squash_instr got %h want 0000", ifidInstr); end
        n_checks++; if (ifidValid !== 1'b0) begin n_fail++; $display("FAIL br_squash_valid got %b want 0", ifidValid); end
        n_checks++; if (ifidPc !== 16'h0012) begin n_fail++; $display("FAIL br_squash_ifidpc got %h want 0012", ifidPc); end
        n_checks++; if (brCount !== ONE_REDIR) begin n_fail++; $display("FAIL br_count got %h want %h", brCount, ONE_REDIR); end
        jmpTrue = 1'b0;
        instrIn = 16'h5555;
        step();
        n_checks++; if (pcOut !== 16'h000A) begin n_fail++; $display("FAIL br_after_pc got %h want 000a", pcOut); end
        n_checks++; if (ifidInstr !== 16'h5555) begin n_fail++; $display("FAIL br_target_instr got %h want 5555", ifidInstr); end
        n_checks++; if (ifidPc !== 16'h0008) begin n_fail++; $display("FAIL br_target_ifidpc got %h want 0008", ifidPc); end
        n_checks++; if (ifidValid !== 1'b1) begin n_fail++; $display("FAIL br_target_valid got %b want 1", ifidValid); end
    endtask

    task automatic test_stall_branch();
        do_reset();
        repeat (3) step();
        stall    = 1'b1;
        jmpTrue  = 1'b1;
        brOffset = 8'h04;
        instrIn  = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pcOut !== 16'h0006) begin n_fail++; $display("FAIL stall_pc[%0d] got %h want 0006", i, pcOut); end
            n_checks++; if (ifidInstr !== 16'h1111) begin n_fail++; $display("FAIL stall_instr[%0d] got %h want 1111", i, ifidInstr); end
            n_checks++; if (ifidPc !== 16'h0004) begin n_fail++; $display("FAIL stall_ifidpc[%0d] got %h want 0004", i, ifidPc); end
            n_checks++; if (ifidValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b want 1", i, ifidValid); end
            n_checks++; if (brCount !== 16'h0000) begin n_fail++; $display("FAIL stall_count[%0d] got %h want 0000", i, brCount); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (pcOut !== 16'h000C) begin n_fail++; $display("FAIL stall_redir_pc got %h want 000c", pcOut); end
        n_checks++; if (ifidValid !== 1'b0) begin n_fail++; $display("FAIL stall_redir_valid got %b want 0", ifidValid); end
        n_checks++; if (ifidPc !== 16'h0006) begin n_fail++; $display("FAIL stall_redir_ifidpc got %h want 0006", ifidPc); end
        n_checks++; if (brCount !== ONE_REDIR) begin n_fail++; $display("FAIL stall_redir_count got %h want %h", brCount, ONE_REDIR); end
        jmpTrue = 1'b0;
        stall   = 1'b1;
        step();
        stall = 1'b0;
        instrIn = 16'h4444;
        step();
        n_checks++; if (ifidInstr !== 16'h4444 || ifidPc !== 16'h000C) begin n_fail++; $display("FAIL stall_resume got %h@%h want 4444@000c", ifidInstr, ifidPc); end
    endtask

    task automatic test_jump_priority();
        do_reset();
        step();
        jumpTrue = 1'b1;
        jumpAddr = 16'h0400;
        jmpTrue  = 1'b1;
        brOffset = 8'h10;
        step();
        n_checks++; if (pcOut !== 16'h0400) begin n_fail++; $display("FAIL jump_pc got %h want 0400", pcOut); end
        n_checks++; if (ifidValid !== 1'b0) begin n_fail++; $display("FAIL jump_valid got %b want 0", ifidValid); end
        n_checks++; if (brCount !== ONE_REDIR) begin n_fail++; $display("FAIL jump_count got %h want %h", brCount, ONE_REDIR); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (16) step();
        n_checks++; if (pcOut !== 16'h0020) begin n_fail++; $display("FAIL halt_setup_pc got %h want 0020", pcOut); end
        instrIn = 16'hFFFF;
        step();
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b want 1", halted); end
        n_checks++; if (pcOut !== 16'h0020) begin n_fail++; $display("FAIL halt_pc got %h want 0020", pcOut); end
        n_checks++; if (ifidInstr !== 16'hFFFF || ifidValid !== 1'b1) begin n_fail++; $display("FAIL halt_instr got %h/%b want ffff/1", ifidInstr, ifidValid); end
        n_checks++; if (ifidPc !== 16'h0020) begin n_fail++; $display("FAIL halt_ifidpc got %h want 0020", ifidPc); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (halted !== 1'b1 || pcOut !== 16'h0020) begin n_fail++; $display("FAIL halt_hold[%0d] got %b/%h want 1/0020", i, halted, pcOut); end
            n_checks++; if (ifidInstr !== 16'h0000 || ifidValid !== 1'b0) begin n_fail++; $display("FAIL halt_bubble[%0d] got %h/%b want 0000/0", i, ifidInstr, ifidValid); end
        end
        rst   = 1'b1;
        stall = 1'b1;
        step();
        rst   = 1'b0;
        stall = 1'b0;
        n_checks++; if (halted !== 1'b0 || pcOut !== 16'h0000) begin n_fail++; $display("FAIL halt_rst got %b/%h want 0/0000", halted, pcOut); end
    endtask

    task automatic test_halt_squash();
        do_reset();
        repeat (16) step();
        instrIn  = 16'hFFFF;
        jmpTrue  = 1'b1;
        brOffset = 8'h02;
        step();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL squash_halted got %b want 0", halted); end
        n_checks++; if (pcOut !== 16'h0022) begin n_fail++; $display("FAIL squash_pc got %h want 0022", pcOut); end
        n_checks++; if (ifidInstr !== 16'h0000 || ifidValid !== 1'b0) begin n_fail++; $display("FAIL squash_ifid got %h/%b want 0000/0", ifidInstr, ifidValid); end
    endtask

    task automatic test_wrap();
        do_reset();
        jumpTrue = 1'b1;
        jumpAddr = 16'hFFFE;
        step();
        jumpTrue = 1'b0;
        n_checks++; if (pcOut !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_setup_pc got %h want fffe", pcOut); end
        instrIn = 16'h6666;
        step();
        n_checks++; if (pcOut !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h want 0000", pcOut); end
        n_checks++; if (ifidPc !== 16'hFFFE || ifidInstr !== 16'h6666) begin n_fail++; $display("FAIL wrap_ifid got %h@%h want 6666@fffe", ifidInstr, ifidPc); end
        jmpTrue  = 1'b1;
        brOffset = 8'h02;
        step();
        jmpTrue = 1'b0;
        n_checks++; if (pcOut !== 16'h0002) begin n_fail++; $display("FAIL wrap_br_pc got %h want 0002", pcOut); end
    endtask

    task automatic test_rst_override();
        do_reset();
        repeat (4) step();
        stall   = 1'b1;
        jmpTrue = 1'b1;
        step();
        rst     = 1'b1;
        stall   = 1'b0;
        jumpTrue = 1'b1;
        jumpAddr = 16'h0800;
        step();
        rst = 1'b0;
        idle_inputs();
        n_checks++; if (pcOut !== 16'h0000 || ifidValid !== 1'b0) begin n_fail++; $display("FAIL rst_override got %h/%b want 0000/0", pcOut, ifidValid); end
        n_checks++; if (brCount !== 16'h0000) begin n_fail++; $display("FAIL rst_override_count got %h want 0000", brCount); end
    endtask

`ifdef FETCH_BRCOUNT_EN
    task automatic test_saturate();
        do_reset();
        jumpTrue = 1'b1;
        jumpAddr = 16'h0000;
        repeat (65535) @(posedge clk);
        #1;
        n_checks++; if (brCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", brCount); end
        step();
        step();
        n_checks++; if (brCount !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffff", brCount); end
        idle_inputs();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_branch();
        test_jump_priority();
        test_halt();
        test_halt_squash();
        test_wrap();
        test_rst_override();
`ifdef FETCH_BRCOUNT_EN
        test_saturate();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage of the 16-bit 5-stage pipeline: owns the program counter and the IF/ID pipeline register, and is the direct consumer of the ID-stage branch comparator's `jmpTrue`. It resolves next-PC selection (sequential, taken branch, absolute jump), applies hazard-unit stalls, squashes the wrong-path instruction on redirect, and stops fetch on HALT. It optionally provides a taken-redirect counter for performance analysis.

## Interface
- `NOP_WORD`, 16'h0000: instruction word injected into IF/ID on squash or halt.
- `HALT_WORD`, 16'hFFFF: encoding that stops fetch.
- `RESET_PC`, 16'h0000: PC value after reset.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `stall  in  1`: from hazard unit; hold PC and IF/ID.
- `jmpTrue  in  1`: comparator result for the branch currently in ID.
- `brOffset  in  8`: signed word offset of the ID-stage branch.
- `jumpTrue  in  1`: unconditional absolute jump in ID.
- `jumpAddr  in  16`: absolute jump target (byte address).
- `instrIn  in  16`: instruction memory read data for address `pcOut`; combinational, same cycle.
- `pcOut  out  16`: current fetch address.
- `ifidInstr  out  16`: IF/ID instruction register.
- `ifidPc  out  16`: PC of `ifidInstr`.
- `ifidValid  out  1`: 0 when IF/ID holds a bubble.
- `halted  out  1`: FSM in HALT.
- `brCount  out  16`: taken-redirect count (see Configuration).

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Redirect request: `redir = (jmpTrue | jumpTrue) & ~stall`. `jmpTrue` and `jumpTrue` are ignored while `stall`=1 because operands are not yet valid.
- Branch target: `ifidPc + {{7{brOffset[7]}}, brOffset, 1'b0}`, 16-bit and wrapping mod 2^16. Jump target is `jumpAddr`. If both requests are set, `jumpTrue` wins.
- Per-edge priority is rst > redir > stall > normal.
- **redir** (any state):
  - `pcOut` <= target.
  - `ifidInstr` <= NOP_WORD, `ifidValid` <= 0, `ifidPc` <= `pcOut`.
  - State <= RUN. The older branch squashes a younger fetched HALT.
- **stall** (no redir): `pcOut`, IF/ID and state are held.
- **RUN normal**:
  - `ifidInstr` <= `instrIn`, `ifidPc` <= `pcOut`, `ifidValid` <= 1.
  - If `instrIn == HALT_WORD`: `pcOut` is held and state <= HALT.
  - Otherwise `pcOut` <= `pcOut + 2`, wrapping 16'hFFFE -> 16'h0000.
- **HALT normal**: `pcOut` is held; `ifidInstr` <= NOP_WORD and `ifidValid` <= 0 from the second HALT cycle on. The HALT instruction itself advances down the pipe once.
- `halted` = (state == HALT).

## Timing
- Reset values: `pcOut`=RESET_PC, `ifidInstr`=NOP_WORD, `ifidPc`=0, `ifidValid`=0, `halted`=0, `brCount`=0, state RUN.
- Fetch-to-IF/ID latency is 1 cycle.
- Redirect penalty is 1 bubble: `jmpTrue` in cycle N, target fetched in N+1, target in ID in N+2.
- The `stall` to hold effect is immediate at the next edge. Nothing is lost or duplicated across a stall of any length.
- `rst` asserted mid-stall, mid-redirect or in HALT overrides everything at that edge.

## Configuration
- `FETCH_BRCOUNT_EN` defined:
  - `brCount` increments by 1 on every edge with `redir`=1 and `rst`=0.
  - Saturates at 16'hFFFF.
  - Cleared only by `rst`.
- `FETCH_BRCOUNT_EN` undefined: no counter register exists and `brCount` is tied to 16'h0000.

## Test plan
- **Reset / sequential fetch:** after `rst`, `instrIn` = 16'h1234, 16'h2345, 16'h3456 on successive cycles. Required: `pcOut` 0, 2, 4, 6; `ifidInstr` lags one cycle with `ifidPc` 0, 2, 4; `ifidValid`=1 from the first post-reset edge.
- **Taken branch:** `ifidPc`=16'h0010, `brOffset`=8'hFC, `jmpTrue`=1 for one cycle. Required: next `pcOut`=16'h0008, `ifidInstr`=NOP with `ifidValid`=0 for one cycle; `brCount`=1 when `FETCH_BRCOUNT_EN` is defined.
- **Stall vs branch:** `stall`=1 and `jmpTrue`=1 for 3 cycles, then `stall`=0 with `jmpTrue`=1. Required: PC and IF/ID frozen for 3 cycles, redirect only on the 4th edge; `brCount`=1.
- **Jump priority:** `jumpTrue`=1, `jumpAddr`=16'h0400 and `jmpTrue`=1 in the same cycle. Required: `pcOut`=16'h0400.
- **HALT and squash:**
  - `instrIn`=16'hFFFF at `pcOut`=16'h0020 with no redirect. Required: `halted`=1, `pcOut` stays 16'h0020, IF/ID holds HALT then bubbles.
  - Repeat with `jmpTrue`=1 on the HALT-fetch edge. Required: `halted`=0 and PC = branch target.
- **Wrap and saturate:**
  - PC at 16'hFFFE. Required: next `pcOut`=16'h0000.
  - With `FETCH_BRCOUNT_EN`, force 65536 redirects. Required: `brCount` holds 16'hFFFF.
